// File: rtl/sccb_init_seq.sv
// SCCB register-table initialisation sequencer: after a power-up wait it walks a
// table of {reg,val} entries, issuing SCCB writes with retry, timed delays and an end marker.
module sccb_init_seq #(
    parameter int TBL_AW      = 8,
    parameter int PWRUP_CYC   = 1000000,
    parameter int DLY_UNIT    = 100000,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TBL_AW:0]   wr_count
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_PWRUP  = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_WRITE  = 4'd4;
    localparam logic [3:0] S_WAIT   = 4'd5;
    localparam logic [3:0] S_DELAY  = 4'd6;
    localparam logic [3:0] S_FINISH = 4'd7;
    localparam logic [3:0] S_FAIL   = 4'd8;

    // One shared counter serves power-up, delay and timeout; it is sized for the largest.
    localparam int DLY_MAX = 255 * DLY_UNIT;
    localparam int MAX_A   = (PWRUP_CYC > DLY_MAX) ? PWRUP_CYC : DLY_MAX;
    localparam int CNT_MAX = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]  PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [RTY_W-1:0]  RETRY_LIM  = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0]  RTY_ONE    = RTY_W'(1);
    localparam logic [TBL_AW-1:0] ADDR_LAST  = {TBL_AW{1'b1}};
    localparam logic [TBL_AW-1:0] ADDR_ONE   = TBL_AW'(1);
    localparam logic [TBL_AW:0]   WC_ONE     = (TBL_AW + 1)'(1);
    localparam logic [7:0]        REG_END    = 8'hFF;
    localparam logic [7:0]        REG_DLY    = 8'hFE;

    logic [3:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [RTY_W-1:0] retry_r;
    logic [7:0]       ent_reg_s;
    logic [7:0]       ent_val_s;
    logic [CNT_W-1:0] dly_load_s;
    logic             adv_s;
    logic             fail_s;

    assign ent_reg_s  = tbl_data[15:8];
    assign ent_val_s  = tbl_data[7:0];
    assign dly_load_s = CNT_W'(32'(ent_val_s) * 32'(DLY_UNIT) - 32'd1);

    // Decide whether this cycle moves to the next entry or records a failed attempt.
    always_comb begin
        adv_s  = 1'b0;
        fail_s = 1'b0;
        case (state_r)
            S_DECODE: adv_s = (ent_reg_s == REG_DLY) && (ent_val_s == 8'h00);
            S_DELAY:  adv_s = (cnt_r == '0);
            S_WAIT: begin
                if (sccb_done) begin
                    adv_s  = !sccb_nack;
                    fail_s = sccb_nack;
                end else begin
                    fail_s = (cnt_r == TMO_LAST);
                end
            end
            default: begin
                adv_s  = 1'b0;
                fail_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, counters and all registered outputs.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            retry_r  <= '0;
            tbl_addr <= '0;
            sccb_req <= 1'b0;
            sccb_reg <= 8'h00;
            sccb_val <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_count <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_FINISH, S_FAIL: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        wr_count <= '0;
                        tbl_addr <= '0;
                        cnt_r    <= '0;
                        busy     <= 1'b1;
                        state_r  <= S_PWRUP;
                    end
                end
                S_PWRUP: begin
                    if (cnt_r == PWRUP_LAST) begin
                        cnt_r   <= '0;
                        state_r <= S_FETCH;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_FETCH: state_r <= S_DECODE;
                S_DECODE: begin
                    if (ent_reg_s == REG_END) begin
                        state_r <= S_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (ent_reg_s == REG_DLY) begin
                        // A zero-length delay is handled by the advance path below.
                        if (ent_val_s != 8'h00) begin
                            cnt_r   <= dly_load_s;
                            state_r <= S_DELAY;
                        end
                    end else begin
                        sccb_reg <= ent_reg_s;
                        sccb_val <= ent_val_s;
                        retry_r  <= '0;
                        state_r  <= S_WRITE;
                    end
                end
                S_DELAY: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_WRITE: begin
                    sccb_req <= 1'b1;
                    cnt_r    <= '0;
                    state_r  <= S_WAIT;
                end
                S_WAIT: begin
                    if (sccb_done) begin
                        sccb_req <= 1'b0;
                        if (!sccb_nack) begin
                            wr_count <= wr_count + WC_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            // Retry re-enters WRITE with sccb_req low for that cycle.
            if (fail_s) begin
                sccb_req <= 1'b0;
                if (retry_r < RETRY_LIM) begin
                    retry_r <= retry_r + RTY_ONE;
                    state_r <= S_WRITE;
                end else begin
                    state_r <= S_FAIL;
                    busy    <= 1'b0;
                    err     <= 1'b1;
                end
            end

            if (adv_s) begin
                if (tbl_addr == ADDR_LAST) begin
                    state_r <= S_FINISH;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    tbl_addr <= tbl_addr + ADDR_ONE;
                    state_r  <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq: registered table ROM model plus an SCCB slave
// model with 5-cycle ack latency, NACK injection on register 0x3A and a silent mode.
module tb_sccb_init_seq;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_data;
    logic          sccb_req;
    logic [7:0]    sccb_reg;
    logic [7:0]    sccb_val;
    logic          sccb_done = 1'b0;
    logic          sccb_nack = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   wr_count;

    logic [15:0] tbl [16];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_req = 0;
    int          rise_edge [32];
    logic [15:0] req_log [32];
    logic        req_q = 1'b0;
    logic        rsp_hold = 1'b0;
    int          rsp_cnt = 0;
    int          nack_used = 0;
    int          nack_limit = 0;
    logic        clr_log = 1'b0;
    logic        silent = 1'b0;
    int          last_wc = 0;
    int          mono_bad = 0;
    int          end_cyc = 0;

    sccb_init_seq #(
        .TBL_AW(4), .PWRUP_CYC(10), .DLY_UNIT(4), .MAX_RETRY(2), .TIMEOUT_CYC(50)
    ) dut (
        .axi_clk(clk), .axi_rst(rst), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sccb_req(sccb_req), .sccb_reg(sccb_reg), .sccb_val(sccb_val),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .busy(busy), .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Table ROM with one cycle read latency.
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // SCCB slave model and request logger (rise_edge holds the edge index that saw the rise).
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        req_q     <= sccb_req;
        sccb_done <= 1'b0;
        sccb_nack <= 1'b0;
        if (clr_log) begin
            n_req     <= 0;
            nack_used <= 0;
        end else if (sccb_req && !req_q && n_req < 32) begin
            req_log[n_req]   <= {sccb_reg, sccb_val};
            rise_edge[n_req] <= cyc + 1;
            n_req            <= n_req + 1;
        end
        if (!sccb_req) begin
            rsp_cnt  <= 0;
            rsp_hold <= 1'b0;
        end else if (!rsp_hold && !silent) begin
            if (rsp_cnt == 4) begin
                sccb_done <= 1'b1;
                rsp_hold  <= 1'b1;
                rsp_cnt   <= 0;
                if (sccb_reg == 8'h3A && nack_used < nack_limit) begin
                    sccb_nack <= 1'b1;
                    nack_used <= nack_used + 1;
                end
            end else begin
                rsp_cnt <= rsp_cnt + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        for (int i = 0; i < 16; i++) tbl[i] = 16'hFF00;
        tbl[0] = e0;
        tbl[1] = e1;
        tbl[2] = e2;
    endtask

    task automatic go(output int k0);
        @(negedge clk);
        clr_log = 1'b1;
        @(negedge clk);
        clr_log = 1'b0;
        start   = 1'b1;
        k0      = cyc + 1;
        last_wc = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic track_wc();
        if (int'(wr_count) < last_wc) mono_bad++;
        last_wc = int'(wr_count);
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
            track_wc();
        end
        check_val("run_ends", 32'(busy), 32'd0);
        end_cyc = cyc;
    endtask

    initial begin
        int k0;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        load(16'hFF00, 16'hFF00, 16'hFF00);
        repeat (3) @(negedge clk);
        check_val("rst_req", 32'(sccb_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_addr", 32'(tbl_addr), 32'd0);
        check_val("rst_wrcnt", 32'(wr_count), 32'd0);
        check_val("rst_reg", 32'({sccb_reg, sccb_val}), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_val("idle_hold_busy", 32'(busy), 32'd0);
        check_val("idle_hold_addr", 32'(tbl_addr), 32'd0);

        // Two plain writes then end marker
        load(16'h1280, 16'h1101, 16'hFF00);
        go(k0);
        wait_end(500);
        check_val("basic_nreq", 32'(n_req), 32'd2);
        check_val("basic_req0", 32'(req_log[0]), 32'h1280);
        check_val("basic_req1", 32'(req_log[1]), 32'h1101);
        check_val("basic_wrcnt", 32'(wr_count), 32'd2);
        check_val("basic_done", 32'(done), 32'd1);
        check_val("basic_err", 32'(err), 32'd0);
        check_val("basic_addr", 32'(tbl_addr), 32'd2);

        // Delay of 3 units (12 cycles) versus zero delay
        load(16'hFE03, 16'h4010, 16'hFF00);
        go(k0);
        wait_end(500);
        check_val("dly3_gap", 32'(rise_edge[0] - k0), 32'd28);
        check_val("dly3_req", 32'(req_log[0]), 32'h4010);
        check_val("dly3_wrcnt", 32'(wr_count), 32'd1);
        check_val("dly3_done", 32'(done), 32'd1);
        load(16'hFE00, 16'h4010, 16'hFF00);
        go(k0);
        wait_end(500);
        check_val("dly0_gap", 32'(rise_edge[0] - k0), 32'd16);
        check_val("dly0_nreq", 32'(n_req), 32'd1);

        // Two NACKs recover, three NACKs abort
        nack_limit = 2;
        load(16'h3A55, 16'hFF00, 16'hFF00);
        go(k0);
        wait_end(500);
        check_val("nack2_nreq", 32'(n_req), 32'd3);
        check_val("nack2_req2", 32'(req_log[2]), 32'h3A55);
        check_val("nack2_done", 32'(done), 32'd1);
        check_val("nack2_err", 32'(err), 32'd0);
        check_val("nack2_wrcnt", 32'(wr_count), 32'd1);
        nack_limit = 3;
        load(16'h1280, 16'h3A55, 16'hFF00);
        go(k0);
        wait_end(500);
        check_val("nack3_nreq", 32'(n_req), 32'd4);
        check_val("nack3_err", 32'(err), 32'd1);
        check_val("nack3_done", 32'(done), 32'd0);
        check_val("nack3_wrcnt", 32'(wr_count), 32'd1);
        check_val("nack3_addr", 32'(tbl_addr), 32'd1);
        nack_limit = 0;

        // Silent slave: three 50-cycle timeouts
        silent = 1'b1;
        load(16'h1280, 16'hFF00, 16'hFF00);
        go(k0);
        check_val("restart_err_clr", 32'(err), 32'd0);
        check_val("restart_busy", 32'(busy), 32'd1);
        wait_end(1000);
        check_val("tmo_end_cyc", 32'(end_cyc - k0), 32'd165);
        check_val("tmo_nreq", 32'(n_req), 32'd3);
        check_val("tmo_first_rise", 32'(rise_edge[0] - k0), 32'd14);
        check_val("tmo_retry_gap", 32'(rise_edge[1] - rise_edge[0]), 32'd51);
        check_val("tmo_err", 32'(err), 32'd1);
        check_val("tmo_wrcnt", 32'(wr_count), 32'd0);
        silent = 1'b0;

        // Full table without an end marker
        for (int i = 0; i < 16; i++) tbl[i] = {8'(8'h20 + i), 8'(8'hA0 + i)};
        go(k0);
        wait_end(2000);
        check_val("full_wrcnt", 32'(wr_count), 32'd16);
        check_val("full_nreq", 32'(n_req), 32'd16);
        check_val("full_last_req", 32'(req_log[15]), 32'h2FAF);
        check_val("full_done", 32'(done), 32'd1);
        check_val("full_addr", 32'(tbl_addr), 32'd15);

        // Reset asserted mid-WAIT
        silent = 1'b1;
        load(16'h1280, 16'hFF00, 16'hFF00);
        go(k0);
        n = 0;
        while (!sccb_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("midrst_req_seen", 32'(sccb_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_val("midrst_req", 32'(sccb_req), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_err", 32'(err), 32'd0);
        check_val("midrst_addr", 32'(tbl_addr), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        silent = 1'b0;
        repeat (15) @(negedge clk);
        check_val("postrst_idle", 32'(busy), 32'd0);
        check_val("postrst_req", 32'(sccb_req), 32'd0);

        // Second start while busy is ignored
        load(16'h1001, 16'h1102, 16'h1203);
        tbl[3] = 16'h1304;
        tbl[4] = 16'hFF00;
        mono_bad = 0;
        go(k0);
        n = 0;
        while (wr_count != 5'd2 && n < 300) begin
            @(negedge clk);
            n++;
            track_wc();
        end
        check_val("busy_at_restart", 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        track_wc();
        wait_end(1000);
        check_val("ign_wrcnt", 32'(wr_count), 32'd4);
        check_val("ign_nreq", 32'(n_req), 32'd4);
        check_val("ign_done", 32'(done), 32'd1);
        check_val("ign_addr", 32'(tbl_addr), 32'd4);
        check_val("ign_monotonic", 32'(mono_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_init_seq.md
SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 The block SHALL have parameter TBL_AW, default 8, giving the register-table address width.
REQ-002 The block SHALL have parameter PWRUP_CYC, default 1000000, giving the power-up wait in clock cycles.
REQ-003 The block SHALL have parameter DLY_UNIT, default 100000, giving the cycles per delay-entry count.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, giving the retries allowed per entry after a failed write.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 200000, giving the maximum cycles to wait for sccb_done.
REQ-006 The block SHALL have port axi_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port axi_rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a configuration run.
REQ-009 The block SHALL have port tbl_addr, output, TBL_AW bits: register-table read address.
REQ-010 The block SHALL have port tbl_data, input, 16 bits: table entry {reg[15:8], val[7:0]}, valid one cycle after tbl_addr.
REQ-011 The block SHALL have port sccb_req, output, 1 bit: write request to the SCCB controller.
REQ-012 The block SHALL have port sccb_reg, output, 8 bits: register address for the SCCB write.
REQ-013 The block SHALL have port sccb_val, output, 8 bits: data byte for the SCCB write.
REQ-014 The block SHALL have port sccb_done, input, 1 bit: single-cycle pulse when the SCCB write completes.
REQ-015 The block SHALL have port sccb_nack, input, 1 bit: qualified by sccb_done; 1 means the slave NACKed.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-017 The block SHALL have port done, output, 1 bit: level, high after a successful run until the next accepted start.
REQ-018 The block SHALL have port err, output, 1 bit: level, high after an aborted run until the next accepted start.
REQ-019 The block SHALL have port wr_count, output, TBL_AW+1 bits: number of writes acknowledged in the current run.

Function
REQ-020 The block SHALL implement states IDLE, PWRUP, FETCH, DECODE, WRITE, WAIT, DELAY, FINISH and FAIL.
REQ-021 In IDLE, FINISH or FAIL, a start pulse SHALL clear done, err and wr_count, set tbl_addr=0 and enter PWRUP.
REQ-022 A start pulse SHALL be ignored while busy is high.
REQ-023 PWRUP SHALL wait exactly PWRUP_CYC cycles and then enter FETCH.
REQ-024 FETCH SHALL present tbl_addr, and the block SHALL sample tbl_data in DECODE on the following cycle.
REQ-025 In DECODE, reg==0xFF SHALL enter FINISH (end marker).
REQ-026 In DECODE, reg==0xFE SHALL enter DELAY for val*DLY_UNIT cycles; val==0 SHALL give zero delay and proceed directly to the next entry.
REQ-027 In DECODE, any other reg value SHALL latch sccb_reg/sccb_val, clear the retry counter and enter WRITE.
REQ-028 WRITE SHALL assert sccb_req, hold sccb_reg/sccb_val stable, and enter WAIT on the next cycle.
REQ-029 sccb_req SHALL remain high in WAIT until sccb_done is sampled, and SHALL be low on the cycle after sccb_done.
REQ-030 sccb_done sampled while sccb_req is low SHALL be ignored.
REQ-031 sccb_done with sccb_nack=0 SHALL increment wr_count and advance to the next entry.
REQ-032 sccb_done with sccb_nack=1, or TIMEOUT_CYC cycles in WAIT without sccb_done, SHALL count one failure.
REQ-033 After a failure, the block SHALL re-enter WRITE (sccb_req low for at least 1 cycle) if retries < MAX_RETRY, and SHALL otherwise enter FAIL.
REQ-034 Advancing to the next entry SHALL increment tbl_addr and re-enter FETCH.
REQ-035 If the entry at tbl_addr = 2^TBL_AW-1 completes without an end marker, the block SHALL enter FINISH (no wrap).
REQ-036 FINISH SHALL set done=1 and FAIL SHALL set err=1; in both, busy=0, and tbl_addr SHALL hold the last entry address.
REQ-037 busy SHALL be 1 in every state except IDLE, FINISH and FAIL.
REQ-038 All outputs SHALL be registered.
REQ-039 Delay, power-up and timeout counters SHALL be sized with $clog2 of their maximum, and all comparisons SHALL be exact (no off-by-one).

Reset
REQ-040 On axi_rst=1, the block SHALL immediately force state IDLE and drive sccb_req=0, busy=0, done=0, err=0, tbl_addr=0, sccb_reg=0, sccb_val=0 and wr_count=0, and SHALL clear all counters.
REQ-041 Reset asserted mid-write SHALL drop sccb_req asynchronously, and no partial-run status SHALL survive reset.
REQ-042 After reset release, the block SHALL stay in IDLE until a start pulse.

Verification (sim parameters: TBL_AW=4, PWRUP_CYC=10, DLY_UNIT=4, MAX_RETRY=2, TIMEOUT_CYC=50)
REQ-043 A bench SHALL cover: table {0x1280,0x1101,0xFF00}, model acks every write after 5 cycles -> two requests (0x12/0x80, 0x11/0x01), wr_count=2, done=1, err=0.
REQ-044 A bench SHALL cover: table {0xFE03,0x4010,0xFF00} -> sccb_req for 0x40 rises no earlier than 12 cycles after decode of 0xFE03.
REQ-045 A bench SHALL cover: model NACKs 0x3A twice then acks -> three requests for 0x3A, done=1; NACKs three times -> err=1, wr_count unchanged, busy=0.
REQ-046 A bench SHALL cover: model never returns sccb_done -> 3 timeouts of 50 cycles each, then err=1.
REQ-047 A bench SHALL cover: a full 16-entry table with no 0xFF marker -> 16 writes, done=1, tbl_addr=15.
REQ-048 A bench SHALL cover: axi_rst pulsed during WAIT -> sccb_req=0 the same cycle; a second start while busy -> ignored (wr_count continues monotonically).
